// File: rtl/iris_pkg.sv
// Shared defaults and arbitration mode encodings for the iris memory arbiter.
package iris_pkg;

   localparam int IRIS_N_CORES    = 8;
   localparam int IRIS_DATA_WIDTH = 24;
   localparam int IRIS_ADDR_WIDTH = 16;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   // Width of a core index; a single core still needs one bit.
   function automatic int iris_id_width(input int n_cores);
      return (n_cores > 1) ? $clog2(n_cores) : 1;
   endfunction

endpackage

// File: rtl/iris_rr_arbiter.sv
// Single-grant arbiter: round-robin from a rotating pointer or fixed lowest-index priority.
module iris_rr_arbiter
   import iris_pkg::*;
#(
   parameter int N_CORES  = IRIS_N_CORES,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_CORES-1:0] valid,
   output logic [N_CORES-1:0] grant,
   input  logic               advance
);

   localparam int PW = iris_id_width(N_CORES);

   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] ptr_next;
   logic          found;
   int            idx;

   // In fixed mode the search order is simply 0..N-1; the pointer is ignored.
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      idx      = 0;
      ptr_next = ptr_reg;
      for (int k = 0; k < N_CORES; k++) begin
         idx = (ARB_MODE == ARB_FIXED) ? k : (int'(ptr_reg) + k) % N_CORES;
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
            ptr_next   = PW'((idx + 1) % N_CORES);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (advance) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/iris_mem_arbiter.sv
// Multi-core single-port memory arbiter: one registered memory command per cycle,
// fixed-latency completion pulses routed back to the issuing core.
module iris_mem_arbiter
   import iris_pkg::*;
#(
   parameter int N_CORES     = IRIS_N_CORES,
   parameter int DATA_WIDTH  = IRIS_DATA_WIDTH,
   parameter int ADDR_WIDTH  = IRIS_ADDR_WIDTH,
   parameter int MEM_LATENCY = 1,
   parameter int ARB_MODE    = ARB_RR
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_CORES-1:0]            req_valid,
   output logic [N_CORES-1:0]            req_ready,
   input  logic [N_CORES-1:0]            req_we,
   input  logic [N_CORES*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_CORES*DATA_WIDTH-1:0] req_wdata,
   output logic [N_CORES-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          mem_ce,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          busy
);

   localparam int IDW = iris_id_width(N_CORES);

   logic [N_CORES-1:0]                 grant;
   logic                               advance;
   logic [N_CORES-1:0][ADDR_WIDTH-1:0] addr_masked;
   logic [N_CORES-1:0][DATA_WIDTH-1:0] wdata_masked;
   logic [N_CORES-1:0][IDW-1:0]        id_masked;
   logic [ADDR_WIDTH-1:0]              sel_addr;
   logic [DATA_WIDTH-1:0]              sel_wdata;
   logic [IDW-1:0]                     sel_id;
   logic                               sel_we;

   logic                               iss_v_reg;
   logic [IDW-1:0]                     iss_id_reg;
   logic [MEM_LATENCY-1:0]             pipe_v_reg;
   logic [MEM_LATENCY-1:0]             pipe_we_reg;
   logic [MEM_LATENCY-1:0][IDW-1:0]    pipe_id_reg;

   iris_rr_arbiter #(
      .N_CORES  (N_CORES),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (req_valid),
      .grant   (grant),
      .advance (advance)
   );

   // Every grant is a transfer, since grant never asserts without valid.
   assign advance   = |grant;
   assign req_ready = grant;

   // Grant is one-hot, so an AND-OR mux selects the winning payload.
   genvar gi;
   generate
      for (gi = 0; gi < N_CORES; gi++) begin : g_mask
         assign addr_masked[gi]  = grant[gi] ? req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]  : '0;
         assign wdata_masked[gi] = grant[gi] ? req_wdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
         assign id_masked[gi]    = grant[gi] ? IDW'(gi) : '0;
      end
   endgenerate

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_id    = '0;
      for (int i = 0; i < N_CORES; i++) begin
         sel_addr  = sel_addr  | addr_masked[i];
         sel_wdata = sel_wdata | wdata_masked[i];
         sel_id    = sel_id    | id_masked[i];
      end
   end

   assign sel_we = |(grant & req_we);

   // Issue stage drives the memory; the shift pipeline tracks the op until mem_rdata is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_v_reg   <= 1'b0;
         iss_id_reg  <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         pipe_v_reg  <= '0;
         pipe_we_reg <= '0;
         pipe_id_reg <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
      end else begin
         iss_v_reg      <= advance;
         iss_id_reg     <= sel_id;
         mem_we         <= sel_we;
         mem_addr       <= sel_addr;
         mem_wdata      <= sel_wdata;
         pipe_v_reg[0]  <= iss_v_reg;
         pipe_we_reg[0] <= mem_we;
         pipe_id_reg[0] <= iss_id_reg;
         for (int k = 1; k < MEM_LATENCY; k++) begin
            pipe_v_reg[k]  <= pipe_v_reg[k-1];
            pipe_we_reg[k] <= pipe_we_reg[k-1];
            pipe_id_reg[k] <= pipe_id_reg[k-1];
         end
         rsp_valid <= pipe_v_reg[MEM_LATENCY-1] ?
                      (N_CORES'(1) << pipe_id_reg[MEM_LATENCY-1]) : '0;
         rsp_rdata <= (pipe_v_reg[MEM_LATENCY-1] && !pipe_we_reg[MEM_LATENCY-1]) ?
                      mem_rdata : '0;
      end
   end

   assign mem_ce = iss_v_reg;
   assign busy   = iss_v_reg | (|pipe_v_reg);

endmodule

// File: tb/tb_iris_mem_arbiter.sv
// Scoreboard bench: three arbiter configurations driven by randomized requesters,
// checked against an order-of-grant memory model with fixed completion latency.
`timescale 1ns/1ps
module tb_iris_mem_arbiter;

   localparam int NC    = 8;
   localparam int DW    = 24;
   localparam int AW    = 16;
   localparam int P_OFF = 0;
   localparam int P_DIR = 1;
   localparam int P_ALL = 2;
   localparam int P_RND = 3;

   typedef struct {
      int             due;
      int             id;
      logic [DW-1:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic mem_init;
   int   phase;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [DW-1:0] init_val(input int a);
      return (a == 16) ? 24'hABCDEF : DW'(a * 32'h0001_0307 + 32'h5A);
   endfunction

   task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cfg
         localparam int ARB = (gi == 1) ? 1 : 0;
         localparam int LAT = (gi == 2) ? 4 : 1;

         logic [NC-1:0]    req_valid, req_ready, req_we, rsp_valid, took;
         logic [NC*AW-1:0] req_addr;
         logic [NC*DW-1:0] req_wdata;
         logic [DW-1:0]    rsp_rdata, mem_wdata, mem_rdata;
         logic [AW-1:0]    mem_addr;
         logic             mem_ce, mem_we, busy;
         logic [DW-1:0]    mem [256];
         logic [DW-1:0]    rd_pipe [LAT];
         exp_t             q[$];

         iris_mem_arbiter #(
            .N_CORES     (NC),
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .MEM_LATENCY (LAT),
            .ARB_MODE    (ARB)
         ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .mem_ce    (mem_ce),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .busy      (busy)
         );

         // Memory with LAT cycles from the command cycle to valid read data.
         always @(posedge clk) begin
            if (mem_init) begin
               for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
            end else if (mem_ce && mem_we) begin
               mem[mem_addr[7:0]] <= mem_wdata;
            end
            rd_pipe[0] <= mem[mem_addr[7:0]];
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
         end
         assign mem_rdata = rd_pipe[LAT-1];

         task automatic put(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
            req_valid[c]           = 1'b1;
            req_we[c]              = we;
            req_addr[c*AW +: AW]   = a;
            req_wdata[c*DW +: DW]  = d;
         endtask

         // Requesters: hold valid/payload until a transfer edge, then re-arm.
         initial begin
            int s = 0;
            req_valid = '0;
            req_we    = '0;
            req_addr  = '0;
            req_wdata = '0;
            took      = '0;
            forever begin
               @(negedge clk);
               took = req_ready;
               @(posedge clk);
               if (!rst_n) took = '0;
               #1;
               req_valid = req_valid & ~took;
               case (phase)
                  P_DIR: begin
                     if (s == 0)  put(3, 1'b0, 16'h0010, 24'h0);
                     if (s == 6)  put(5, 1'b1, 16'h00FF, 24'h123456);
                     if (s == 7)  put(2, 1'b0, 16'h00FF, 24'h0);
                     if (s == 12) put(7, 1'b0, 16'h0020, 24'h0);
                     s++;
                  end
                  P_ALL, P_RND: begin
                     for (int i = 0; i < NC; i++) begin
                        if (!req_valid[i] && (phase == P_ALL || $urandom_range(0, 2) == 0))
                           put(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
                     end
                  end
                  default: req_valid = '0;
               endcase
            end
         end

         // Reference model and monitor.
         initial begin
            int            ptr;
            int            g;
            int            c;
            logic          exp_ce;
            logic          exp_we;
            logic [AW-1:0] exp_addr;
            logic [DW-1:0] exp_wd;
            logic [NC-1:0] ev;
            logic [DW-1:0] ed;
            exp_t          e;
            logic [DW-1:0] ref_mem [256];
            ptr      = 0;
            exp_ce   = 1'b0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_wd   = '0;
            for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
            forever begin
               @(negedge clk);
               if (!rst_n) begin
                  chk("reset_outputs", gi, 64'({rsp_valid, rsp_rdata, busy, mem_ce, mem_we}), 64'(0));
                  q.delete();
                  ptr    = 0;
                  exp_ce = 1'b0;
               end else begin
                  chk("mem_ce", gi, 64'(mem_ce), 64'(exp_ce));
                  if (exp_ce) begin
                     chk("mem_cmd", gi, 64'({mem_we, mem_addr}), 64'({exp_we, exp_addr}));
                     if (exp_we) chk("mem_wdata", gi, 64'(mem_wdata), 64'(exp_wd));
                  end
                  ev = '0;
                  ed = '0;
                  if (q.size() > 0 && q[0].due == cyc) begin
                     e  = q.pop_front();
                     ev = NC'(1) << e.id;
                     ed = e.data;
                  end
                  chk("rsp_valid", gi, 64'(rsp_valid), 64'(ev));
                  if (ev != '0) chk("rsp_rdata", gi, 64'(rsp_rdata), 64'(ed));
                  chk("busy", gi, 64'(busy), 64'(q.size() > 0));
                  g = -1;
                  for (int k = 0; k < NC; k++) begin
                     c = (ARB == 1) ? k : (ptr + k) % NC;
                     if (g < 0 && req_valid[c]) g = c;
                  end
                  chk("req_ready", gi, 64'(req_ready), (g < 0) ? 64'(0) : (64'(1) << g));
                  exp_ce = (g >= 0);
                  if (g >= 0) begin
                     exp_we   = req_we[g];
                     exp_addr = req_addr[g*AW +: AW];
                     exp_wd   = req_wdata[g*DW +: DW];
                     e.due    = cyc + 2 + LAT;
                     e.id     = g;
                     e.data   = exp_we ? '0 : ref_mem[exp_addr[7:0]];
                     q.push_back(e);
                     if (exp_we) ref_mem[exp_addr[7:0]] = exp_wd;
                     if (ARB == 0) ptr = (g + 1) % NC;
                  end
               end
            end
         end
      end
   endgenerate

   initial begin
      rst_n    = 1'b0;
      mem_init = 1'b1;
      phase    = P_DIR;
      repeat (3) @(posedge clk);
      #2;
      rst_n    = 1'b1;
      mem_init = 1'b0;
      repeat (28) @(posedge clk);
      #2 phase = P_ALL;
      repeat (24) @(posedge clk);
      #2 phase = P_RND;
      repeat (300) @(posedge clk);
      #2 phase = P_ALL;
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      phase = P_OFF;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      phase = P_ALL;
      repeat (24) @(posedge clk);
      #2 phase = P_RND;
      repeat (300) @(posedge clk);
      #2 phase = P_OFF;
      repeat (12) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
